// File: rtl/hd44780_wait_timer.sv
`default_nettype none
// hd44780_wait_timer: four free-running saturating wait counters, restarted together by clr,
// with a selector that picks which done flag drives waitclk. Rev 1.0

module hd44780_wait_timer #(
  parameter int unsigned COUNT0   = 20,
  parameter int unsigned COUNT1   = 20,
  parameter int unsigned COUNT2   = 2500,
  parameter int unsigned COUNT3   = 50000,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [SEL_BITS-1:0]      sel,
  output logic [2**SEL_BITS-1:0]   sel_onehot,
  output logic [3:0]               flags,
  output logic                     waitclk
);

  localparam int unsigned NSEL   = 2**SEL_BITS;
  localparam logic [63:0] LIMITS = {16'(COUNT3), 16'(COUNT2), 16'(COUNT1), 16'(COUNT0)};

  generate
    for (genvar i = 0; i < NSEL; i++) begin : g_dec
      assign sel_onehot[i] = (sel == SEL_BITS'(i));
    end

    for (genvar i = 0; i < 4; i++) begin : g_cnt
      localparam logic [15:0] LIMIT = LIMITS[16*i +: 16];
      logic [15:0] count;

      // Saturating up-counter; clr wins even once the limit is reached.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          count <= '0;
        else if (clr)
          count <= '0;
        else if (count != LIMIT)
          count <= count + 16'd1;
      end

      assign flags[i] = (count == LIMIT);
    end
  endgenerate

  // Selector values >= 4 have all of the low four decode lines clear, so waitclk is 0.
  assign waitclk = |(flags & sel_onehot[3:0]);

endmodule

`default_nettype wire

// File: tb/tb_hd44780_wait_timer.sv
`default_nettype none
// Testbench for hd44780_wait_timer: directed scenarios plus randomized traffic against an
// elapsed-edges reference model.

module tb_hd44780_wait_timer;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic [3:0] flags;
  logic       waitclk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges elapsed since the last restart, capped at the counter width.
  int unsigned elapsed = 0;
  int unsigned lim [4] = '{20, 20, 2500, 50000};

  hd44780_wait_timer dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sel        (sel),
    .sel_onehot (sel_onehot),
    .flags      (flags),
    .waitclk    (waitclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (elapsed >= lim[i]);
    return f;
  endfunction

  function automatic logic [8:0] model_obs(input logic [1:0] s);
    logic [3:0] oh;
    logic [3:0] f;
    oh = 4'b0001 << s;
    f  = model_flags();
    return {oh, f, f[s]};
  endfunction

  // Apply inputs, take one rising edge, advance the model, settle 1 time unit past the edge.
  task automatic step(input logic c, input logic [1:0] s);
    clr = c;
    sel = s;
    @(posedge clk);
    if (!rst || c) elapsed = 0;
    else if (elapsed < 65535) elapsed++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr = 1'b0;
    elapsed = 0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
        errors++;
        $display("FAIL reset sel=%0d: got %b expected %b", s, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
    end
  endtask

  task automatic test_release();
    sel = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 2'd0);
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
        errors++;
        $display("FAIL release edge %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
      if (k == 19 || k == 20) begin
        checks++;
        if (waitclk !== (k == 20)) begin
          errors++;
          $display("FAIL release_edge%0d waitclk: got %b expected %b", k, waitclk, (k == 20));
        end
      end
    end
  endtask

  task automatic test_long_wait();
    step(1'b1, 2'd3);
    for (int k = 1; k <= 50000; k++) begin
      step(1'b0, 2'd3);
      if (k == 49999 || k == 50000 || k % 500 == 0) begin
        checks++;
        if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
          errors++;
          $display("FAIL long edge %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
        end
      end
    end
    checks++;
    if (flags !== 4'b1111 || waitclk !== 1'b1) begin
      errors++;
      $display("FAIL long_final: got flags=%b waitclk=%b expected 1111/1", flags, waitclk);
    end
  endtask

  task automatic test_clr_pulse();
    step(1'b1, 2'd0);
    repeat (2500) step(1'b0, 2'd0);
    checks++;
    if (flags[2] !== 1'b1) begin
      errors++;
      $display("FAIL clr_pulse_pre flag2: got %b expected 1", flags[2]);
    end
    step(1'b1, 2'd0);
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL clr_pulse_after flags: got %b expected 0000", flags);
    end
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 2'd0);
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel) || flags[0] !== (k >= 20)) begin
        errors++;
        $display("FAIL clr_pulse edge %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       exp_w  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    step(1'b1, 2'd0);
    repeat (2500) step(1'b0, 2'd0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (waitclk !== exp_w[s] || sel_onehot !== exp_oh[s]) begin
        errors++;
        $display("FAIL sweep sel=%0d: got w=%b oh=%b expected w=%b oh=%b",
                 s, waitclk, sel_onehot, exp_w[s], exp_oh[s]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 2'd0);
    repeat (1000) step(1'b0, 2'd0);
    checks++;
    if (flags !== 4'b0011 || waitclk !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got flags=%b w=%b expected 0011/1", flags, waitclk);
    end
    #2 rst = 1'b0;
    elapsed = 0;
    #1;
    checks++;
    if (flags !== 4'b0000 || waitclk !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: got flags=%b w=%b expected 0000/0", flags, waitclk);
    end
    #2 rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 2'd1);
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
        errors++;
        $display("FAIL async_restart edge %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
    end
  endtask

  task automatic test_clr_hold();
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 2'($urandom_range(0, 3)));
      checks++;
      if (flags !== 4'b0000 || waitclk !== 1'b0) begin
        errors++;
        $display("FAIL clr_hold cycle %0d: got flags=%b w=%b expected 0000/0", k, flags, waitclk);
      end
    end
    for (int k = 1; k <= 2600; k++) begin
      step(1'b0, 2'd2);
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
        errors++;
        $display("FAIL clr_hold_release edge %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)));
      checks++;
      if ({sel_onehot, flags, waitclk} !== model_obs(sel)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", k, {sel_onehot, flags, waitclk}, model_obs(sel));
      end
      if ($urandom_range(0, 255) == 0) begin
        #2 rst = 1'b0;
        elapsed = 0;
        #1;
        checks++;
        if (flags !== 4'b0000 || waitclk !== 1'b0) begin
          errors++;
          $display("FAIL random_reset cycle %0d: got flags=%b w=%b expected 0000/0", k, flags, waitclk);
        end
        #1 rst = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    sel = 2'd0;
    test_reset();
    test_release();
    test_long_wait();
    test_clr_pulse();
    test_sweep();
    test_async_reset();
    test_clr_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
